// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the instruction-sequencing controller: opcodes, one-hot
// timing codes, FSM state codes and the datapath strobe bundle.
package cpu_ctrl_pkg;

  // Opcodes (IR[7:4]); 8..E are undefined and execute as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot timing codes driven on the timing output.
  localparam logic [6:0] T0 = 7'h01;
  localparam logic [6:0] T1 = 7'h02;
  localparam logic [6:0] T2 = 7'h04;
  localparam logic [6:0] T3 = 7'h08;
  localparam logic [6:0] T4 = 7'h10;
  localparam logic [6:0] T5 = 7'h20;
  localparam logic [6:0] T6 = 7'h40;

  // FSM state codes; T0..T6 are consecutive so the sequencer can increment.
  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StT0   = 4'd1;
  localparam logic [3:0] StT1   = 4'd2;
  localparam logic [3:0] StT2   = 4'd3;
  localparam logic [3:0] StT3   = 4'd4;
  localparam logic [3:0] StT4   = 4'd5;
  localparam logic [3:0] StT5   = 4'd6;
  localparam logic [3:0] StT6   = 4'd7;
  localparam logic [3:0] StHalt = 4'd8;

  typedef struct packed {
    logic pc_out;
    logic mar_load;
    logic mem_rd;
    logic mem_wr;
    logic ir_load;
    logic ir_out;
    logic pc_inc;
    logic pc_load;
    logic b_load;
    logic acc_load;
    logic acc_out;
    logic out_load;
    logic flag_load;
    logic alu_sub;
  } strobes_t;

  // One-hot timing code for a state; zero in IDLE, HALT and unused codes.
  function automatic logic [6:0] state_timing(logic [3:0] st);
    logic [6:0] t;
    case (st)
      StT0:    t = T0;
      StT1:    t = T1;
      StT2:    t = T2;
      StT3:    t = T3;
      StT4:    t = T4;
      StT5:    t = T5;
      StT6:    t = T6;
      default: t = 7'h00;
    endcase
    return t;
  endfunction

  function automatic logic is_undefined_op(logic [3:0] op);
    return op[3] && (op != OP_HLT);
  endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational decode of FSM state, opcode and acc_zero into the datapath
// strobe bundle, plus flags marking the last state of an instruction and
// states that wait on the memory acknowledge.
module op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output strobes_t   strb,
  output logic       last_state,
  output logic       mem_state
);

  // Moore strobe decode; loads inside memory states fire only on acknowledge.
  always_comb begin
    strb       = '0;
    last_state = 1'b0;
    mem_state  = 1'b0;
    case (state)
      StT0: begin
        strb.pc_out   = 1'b1;
        strb.mar_load = 1'b1;
      end
      StT1: begin
        strb.mem_rd = 1'b1;
        mem_state   = 1'b1;
      end
      StT2: begin
        strb.ir_load = 1'b1;
        strb.pc_inc  = 1'b1;
      end
      StT3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            strb.ir_out   = 1'b1;
            strb.mar_load = 1'b1;
          end
          OP_JMP: begin
            strb.ir_out  = 1'b1;
            strb.pc_load = 1'b1;
            last_state   = 1'b1;
          end
          OP_JZ: begin
            strb.ir_out  = 1'b1;
            strb.pc_load = acc_zero;
            last_state   = 1'b1;
          end
          OP_OUT: begin
            strb.acc_out  = 1'b1;
            strb.out_load = 1'b1;
            last_state    = 1'b1;
          end
          // NOP, HLT and undefined opcodes: no strobes, single execute state.
          default: last_state = 1'b1;
        endcase
      end
      StT4: begin
        case (opcode)
          OP_LDA: begin
            strb.mem_rd = 1'b1;
            mem_state   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            strb.mem_rd = 1'b1;
            strb.b_load = mem_ready;
            mem_state   = 1'b1;
          end
          OP_STA: begin
            strb.acc_out = 1'b1;
            strb.mem_wr  = 1'b1;
            mem_state    = 1'b1;
            last_state   = 1'b1;
          end
          // An opcode that changed mid-instruction ends it rather than hanging.
          default: last_state = 1'b1;
        endcase
      end
      StT5: begin
        case (opcode)
          OP_LDA: begin
            strb.acc_load = 1'b1;
            last_state    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            strb.acc_load = 1'b1;
            strb.alu_sub  = (opcode == OP_SUB);
          end
          default: last_state = 1'b1;
        endcase
      end
      StT6: begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            strb.flag_load = 1'b1;
            last_state     = 1'b1;
          end
          default: last_state = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing controller: state register, memory stall handling,
// run/halt control, retired-instruction counter and sticky illegal flag.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             acc_zero,
  input  logic             mem_ready,
  output logic [6:0]       timing,
  output logic             pc_out,
  output logic             mar_load,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_load,
  output logic             ir_out,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             b_load,
  output logic             acc_load,
  output logic             acc_out,
  output logic             out_load,
  output logic             flag_load,
  output logic             alu_sub,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;
  strobes_t         strb;
  logic             last_state;
  logic             mem_state;
  logic             advance;
  logic             retire;

  op_decode u_op_decode (
    .state      (state_q),
    .opcode     (opcode),
    .acc_zero   (acc_zero),
    .mem_ready  (mem_ready),
    .strb       (strb),
    .last_state (last_state),
    .mem_state  (mem_state)
  );

  assign busy    = (state_q >= StT0) && (state_q <= StT6);
  assign advance = !mem_state || mem_ready;
  assign retire  = busy && advance && last_state;

  // Next-state: step T0..T6, hold memory states until acknowledged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (run) state_d = StT0;
      StHalt: state_d = StHalt;
      default: begin
        if (!busy) begin
          state_d = StIdle;
        end else if (advance) begin
          if (last_state) begin
            state_d = ((state_q == StT3) && (opcode == OP_HLT)) ? StHalt : StT0;
          end else begin
            state_d = state_q + 4'd1;
          end
        end
      end
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Retired-instruction counter; an aborted instruction never reaches retire.
  always_ff @(posedge clk) begin
    if (clear)       count_q <= '0;
    else if (retire) count_q <= count_q + CNT_W'(1);
  end

  // Sticky undefined-opcode flag, latched while the opcode is decoded in T3.
  always_ff @(posedge clk) begin
    if (clear)                                             illegal_q <= 1'b0;
    else if ((state_q == StT3) && is_undefined_op(opcode)) illegal_q <= 1'b1;
  end

  assign timing      = state_timing(state_q);
  assign halted      = (state_q == StHalt);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

  assign pc_out    = strb.pc_out;
  assign mar_load  = strb.mar_load;
  assign mem_rd    = strb.mem_rd;
  assign mem_wr    = strb.mem_wr;
  assign ir_load   = strb.ir_load;
  assign ir_out    = strb.ir_out;
  assign pc_inc    = strb.pc_inc;
  assign pc_load   = strb.pc_load;
  assign b_load    = strb.b_load;
  assign acc_load  = strb.acc_load;
  assign acc_out   = strb.acc_out;
  assign out_load  = strb.out_load;
  assign flag_load = strb.flag_load;
  assign alu_sub   = strb.alu_sub;

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing controller for the simple processor. It steps the one-hot timing states T0–T6, decodes the latched opcode, and drives every datapath strobe for fetch and execute. It also stretches memory states until the memory acknowledges, ends each instruction early once its last state is done, and handles run/halt. It sits between the instruction register, the memory port and the shared-bus datapath.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- clear  in  1  synchronous, active-high reset
- run  in  1  start request, sampled only in IDLE
- opcode  in  4  IR[7:4], valid from the cycle after T2
- acc_zero  in  1  accumulator-zero flag
- mem_ready  in  1  memory acknowledge for the current mem_rd/mem_wr
- timing  out  7  one-hot T0..T6; 0 in IDLE and HALT
- pc_out, mar_load, mem_rd, mem_wr, ir_load, ir_out, pc_inc, pc_load  out  1 each  datapath strobes
- b_load, acc_load, acc_out, out_load, flag_load  out  1 each  datapath strobes
- alu_sub  out  1  0 = add, 1 = subtract
- busy  out  1  high in T0..T6
- halted  out  1  high in HALT
- illegal  out  1  sticky, set on an undefined opcode
- instr_count  out  CNT_W  retired-instruction count

## Operation
- States are IDLE, T0..T6 and HALT. Strobes are Moore decodes of state, opcode and acc_zero.
- Reset: clear=1 forces IDLE on the next edge from any state. All outputs are 0, including instr_count and illegal. clear has priority over run and mem_ready.
- IDLE: run=1 goes to T0; otherwise stay.
- Fetch, common to all opcodes:
  - T0: pc_out, mar_load.
  - T1: mem_rd. Stall while mem_ready=0.
  - T2: ir_load, pc_inc.
- Execute (opcode sampled in T3 and later):
  - 0 NOP: T3 has no strobes; end.
  - 1 LDA:
    - T3: ir_out, mar_load.
    - T4: mem_rd. Stall while mem_ready=0.
    - T5: acc_load, with the memory value on the bus; end.
  - 2 ADD / 3 SUB:
    - T3: as LDA.
    - T4: mem_rd, b_load. Stall while mem_ready=0.
    - T5: acc_load; alu_sub=1 for SUB only.
    - T6: flag_load; end.
  - 4 STA:
    - T3: ir_out, mar_load.
    - T4: acc_out, mem_wr. Stall while mem_ready=0; end.
  - 5 JMP: T3 has ir_out, pc_load; end.
  - 6 JZ: T3 has ir_out, plus pc_load only if acc_zero=1; end.
  - 7 OUT: T3 has acc_out, out_load; end.
  - F HLT: T3 has no strobes; go to HALT.
  - 8–E: treated as NOP; illegal is set at T3.
- End of instruction: the next state is T0 and instr_count increments, wrapping at 2^CNT_W−1 → 0. HLT also counts as retired.
- Stall rules:
  - In a memory state with mem_ready=0, the state holds and mem_rd/mem_wr stays asserted.
  - Loads in that state (ir_load is not in one; b_load is) are gated by mem_ready, so they fire only in the acknowledging cycle.
- HALT: no strobes; run is ignored. Only clear exits.
- illegal clears only on clear.

## Timing
- Instruction length in cycles with mem_ready tied high: NOP/JMP/JZ/OUT 4, STA 5, LDA 6, ADD/SUB 7, HLT 4 then HALT.
- Each cycle of mem_ready=0 in T1 or T4 adds one cycle.
- run=1 in IDLE at edge n gives timing=T0 in cycle n+1.
- instr_count updates on the edge leaving the last state; the new value is visible in the following T0.
- clear during a stall: the next cycle is IDLE with mem_rd=0 and mem_wr=0. The aborted instruction is not counted.
- mem_ready high outside a memory state is ignored.
- opcode changes outside T3..T6 have no effect.

## Structure
- Package cpu_ctrl_pkg:
  - opcode constants (OP_NOP … OP_HLT)
  - one-hot timing constants T0..T6
  - state encoding including IDLE/HALT
- Sub-module op_decode: combinational mapping of state, opcode and acc_zero to the strobe bundle plus a last_state flag. control_unit holds the state register, stall logic, counter and sticky flags.

## Test plan
- Reset, then run: clear=1 for 2 cycles, then run=1 with NOP and mem_ready=1 → timing 0, 01, 02, 04, 08, 01; instr_count=1 in the second T0.
- ADD with a 2-cycle memory stall in T4 → T4 held 3 cycles; mem_rd high for all 3; b_load only in the third; T5 has acc_load with alu_sub=0; T6 has flag_load; 9 cycles total.
- JZ with acc_zero=0, then acc_zero=1 → pc_load low, then high in T3; each instruction 4 cycles.
- HLT, then run pulses → halted=1, timing=0, no strobes for 20 cycles; clear → IDLE, halted=0, instr_count=0.
- Opcode 0xA → executes as NOP; illegal=1 and stays set through the following LDA; LDA takes 6 cycles.
- clear in T1 while mem_ready=0 → next cycle IDLE with mem_rd=0; count unchanged from before reset (0).
